// File: rtl/upload_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upload_arb_pkg
// Description : Shared constants for the USB CDC upload arbiter: FSM state
//               codes, default frame sync bytes and the SRCID field width.
// Revision    : 1.0 - initial release
// ============================================================================
package upload_arb_pkg;

    localparam int         SRCID_W      = 3;
    localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT = 8'h44;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_HDR0  = 3'd1;
    localparam state_t ST_HDR1  = 3'd2;
    localparam state_t ST_SRCID = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_CSUM  = 3'd5;

    // Source index as it appears in the SRCID header byte.
    function automatic logic [7:0] srcid_byte(input logic [SRCID_W-1:0] id);
        return {{(8-SRCID_W){1'b0}}, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/upload_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin select: first request at or after
//               i_ptr, wrapping modulo NUM_SRC.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_SRC)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_SRC);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : upload_arbiter
// Description : Frame-granular round-robin arbiter sharing the USB CDC upload
//               byte channel; wraps each frame as HDR0 HDR1 SRCID payload.
//               Define UPLOAD_CSUM_EN to append an 8-bit checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module upload_arbiter
    import upload_arb_pkg::*;
#(
    parameter int         NUM_SRC = 4,
    parameter int         MAX_LEN = 256,
    parameter logic [7:0] HDR0    = HDR0_DEFAULT,
    parameter logic [7:0] HDR1    = HDR1_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           usb_upload_data,
    output logic                 usb_upload_valid,
    input  logic                 usb_upload_ready,
    output logic                 busy,
    output logic                 frame_trunc
);

    localparam int IDX_W = $clog2(NUM_SRC);

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] grant_q,     grant_d;
    logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [15:0]      len_cnt_q,   len_cnt_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             trunc_q,     trunc_d;
    logic             tail_q,      tail_d;
`ifdef UPLOAD_CSUM_EN
    logic [7:0]       csum_q,      csum_d;
`endif

    logic [NUM_SRC-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_start;
    logic               w_xfer;
    logic               w_can_load;
    logic [7:0]         w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [15:0]        w_len_next;
    logic               w_hit_max;
    logic [IDX_W-1:0]   w_next_ptr;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req (src_valid),
        .i_ptr (rr_ptr_q),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_start     = w_pick_any && (|w_pick_gnt);
    assign w_xfer      = out_valid_q && usb_upload_ready;
    assign w_can_load  = !out_valid_q || usb_upload_ready;
    assign w_sel_data  = src_data[{grant_q, 3'b000} +: 8];
    assign w_sel_valid = src_valid[grant_q];
    assign w_sel_last  = src_last[grant_q];
    assign w_len_next  = len_cnt_q + 16'd1;
    assign w_hit_max   = (w_len_next == 16'(MAX_LEN));
    assign w_next_ptr  = (grant_q == IDX_W'(NUM_SRC-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        len_cnt_d   = len_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        trunc_d     = 1'b0;
        tail_d      = tail_q;
        src_ready   = '0;
`ifdef UPLOAD_CSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    grant_d     = w_pick_idx;
                    out_data_d  = HDR0;
                    out_valid_d = 1'b1;
                    len_cnt_d   = '0;
                    tail_d      = 1'b0;
                    state_d     = ST_HDR0;
                end
            end
            ST_HDR0: begin
                if (w_xfer) begin
                    out_data_d = HDR1;
                    state_d    = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (w_xfer) begin
                    out_data_d = srcid_byte(SRCID_W'(grant_q));
                    state_d    = ST_SRCID;
`ifdef UPLOAD_CSUM_EN
                    csum_d     = srcid_byte(SRCID_W'(grant_q));
`endif
                end
            end
            ST_SRCID, ST_DATA: begin
                // tail_q marks the closing payload byte still waiting in the output register
                if (tail_q) begin
                    if (w_xfer) begin
                        out_valid_d = 1'b0;
                        tail_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_DATA;
                    end
                    if (w_sel_valid && w_can_load) begin
                        src_ready[grant_q] = 1'b1;
                        out_data_d         = w_sel_data;
                        out_valid_d        = 1'b1;
                        len_cnt_d          = w_len_next;
                        state_d            = ST_DATA;
`ifdef UPLOAD_CSUM_EN
                        csum_d             = csum_q + w_sel_data;
`endif
                        if (w_sel_last || w_hit_max) begin
                            trunc_d  = !w_sel_last;
                            rr_ptr_d = w_next_ptr;
`ifdef UPLOAD_CSUM_EN
                            state_d  = ST_CSUM;
`else
                            tail_d   = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef UPLOAD_CSUM_EN
            ST_CSUM: begin
                if (w_xfer) begin
                    if (tail_q) begin
                        out_valid_d = 1'b0;
                        tail_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_data_d = csum_q;
                        tail_d     = 1'b1;
                    end
                end
            end
`endif
            default: begin
                out_valid_d = 1'b0;
                tail_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            len_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            trunc_q     <= 1'b0;
            tail_q      <= 1'b0;
`ifdef UPLOAD_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            len_cnt_q   <= len_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            trunc_q     <= trunc_d;
            tail_q      <= tail_d;
`ifdef UPLOAD_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign usb_upload_data  = out_data_q;
    assign usb_upload_valid = out_valid_q;
    assign busy             = (state_q != ST_IDLE);
    assign frame_trunc      = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_upload_arbiter
// Description : Scoreboard bench for upload_arbiter: a frame-level model
//               predicts the upload byte stream, a monitor checks it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upload_arbiter;

    localparam int         NUM_SRC = 4;
    localparam int         MAX_LEN = 4;
    localparam logic [7:0] HDR0_B  = 8'hAA;
    localparam logic [7:0] HDR1_B  = 8'h44;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic [7:0]           usb_upload_data;
    logic                 usb_upload_valid;
    logic                 usb_upload_ready;
    logic                 busy;
    logic                 frame_trunc;

    upload_arbiter #(
        .NUM_SRC (NUM_SRC),
        .MAX_LEN (MAX_LEN),
        .HDR0    (HDR0_B),
        .HDR1    (HDR1_B)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_last         (src_last),
        .src_ready        (src_ready),
        .usb_upload_data  (usb_upload_data),
        .usb_upload_valid (usb_upload_valid),
        .usb_upload_ready (usb_upload_ready),
        .busy             (busy),
        .frame_trunc      (frame_trunc)
    );

    always #5 clk = ~clk;

    // {last, data} entries: ph is the phase being built, sq what the sources present
    bit [8:0] ph [NUM_SRC][$];
    bit [8:0] sq [NUM_SRC][$];
    bit [8:0] expq [$];   // {frame_end, byte}
    int       checks    = 0;
    int       failures  = 0;
    int       popped    = 0;
    int       trunc_seen = 0;
    int       trunc_exp  = 0;
    int       model_rr   = 0;
    int       duty       = 100;
    bit       acc [NUM_SRC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, want);
        end
    endtask

    // Frame-level reference: round-robin over sources that still hold data.
    task automatic load_phase();
        int       pos [NUM_SRC];
        int       g, n;
        bit       found, closing;
        bit [7:0] sum;
        bit [8:0] e;
        for (int i = 0; i < NUM_SRC; i++) pos[i] = 0;
        forever begin
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                int c;
                c = (model_rr + k) % NUM_SRC;
                if (!found && pos[c] < ph[c].size()) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            if (!found) break;
            expq.push_back({1'b0, HDR0_B});
            expq.push_back({1'b0, HDR1_B});
            expq.push_back({1'b0, 8'(g)});
            sum     = 8'(g);
            n       = 0;
            closing = 1'b0;
            while (!closing) begin
                e = ph[g][pos[g]];
                pos[g]++;
                n++;
                sum     = sum + e[7:0];
                closing = e[8] || (n == MAX_LEN);
                if (n == MAX_LEN && !e[8]) trunc_exp++;
`ifdef UPLOAD_CSUM_EN
                expq.push_back({1'b0, e[7:0]});
`else
                expq.push_back({closing, e[7:0]});
`endif
            end
`ifdef UPLOAD_CSUM_EN
            expq.push_back({1'b1, sum});
`endif
            model_rr = (g + 1) % NUM_SRC;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            foreach (ph[i][j]) sq[i].push_back(ph[i][j]);
            ph[i].delete();
        end
    endtask

    task automatic add_frame(input int src, input int len);
        for (int b = 0; b < len; b++) ph[src].push_back({(b == len - 1), 8'($urandom)});
    endtask

    task automatic drain();
        int cyc;
        bit pending;
        cyc     = 0;
        pending = 1'b1;
        while (pending && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            pending = (expq.size() != 0);
            for (int i = 0; i < NUM_SRC; i++) if (sq[i].size() != 0) pending = 1'b1;
        end
        chk("drain_done", {31'd0, !pending}, 32'd1);
        repeat (3) @(negedge clk);
        chk("busy_after_drain", {31'd0, busy}, 32'd0);
        chk("trunc_count", trunc_seen, trunc_exp);
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NUM_SRC; i++) begin
            bit [8:0] e;
            if (sq[i].size() != 0) begin
                e                  = sq[i][0];
                src_valid[i]       = 1'b1;
                src_last[i]        = e[8];
                src_data[i*8 +: 8] = e[7:0];
            end else begin
                src_valid[i]       = 1'b0;
                src_last[i]        = 1'b0;
                src_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    // Source and sink driver
    initial begin
        src_valid        = '0;
        src_last         = '0;
        src_data         = '0;
        usb_upload_ready = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_SRC; i++) acc[i] = rst_n && src_valid[i] && src_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_SRC; i++)
                if (acc[i] && sq[i].size() != 0) void'(sq[i].pop_front());
            drive_srcs();
            usb_upload_ready = ($urandom_range(0, 99) < duty);
        end
    end

    // Monitor / scoreboard
    initial begin
        bit       have_prev, busy_chk, pv, pr;
        bit [7:0] pd;
        bit [8:0] e;
        have_prev = 1'b0;
        busy_chk  = 1'b0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
                busy_chk  = 1'b0;
                continue;
            end
            if (busy_chk) begin
                chk("busy_low_after_frame", {31'd0, busy}, 32'd0);
                busy_chk = 1'b0;
            end
            if (have_prev && pv && !pr) begin
                chk("hold_valid", {31'd0, usb_upload_valid}, 32'd1);
                chk("hold_data", {24'd0, usb_upload_data}, {24'd0, pd});
            end
            if (frame_trunc) trunc_seen++;
            if (usb_upload_valid && usb_upload_ready) begin
                chk("byte_expected", {31'd0, expq.size() != 0}, 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    popped++;
                    chk("out_byte", {24'd0, usb_upload_data}, {24'd0, e[7:0]});
                    if (e[8]) busy_chk = 1'b1;
                end
            end
            pv = usb_upload_valid;
            pr = usb_upload_ready;
            pd = usb_upload_data;
            have_prev = 1'b1;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"},  {24'd0, usb_upload_data},  32'd0);
        chk({tag, "_valid"}, {31'd0, usb_upload_valid}, 32'd0);
        chk({tag, "_ready"}, {28'd0, src_ready},        32'd0);
        chk({tag, "_busy"},  {31'd0, busy},             32'd0);
        chk({tag, "_trunc"}, {31'd0, frame_trunc},      32'd0);
    endtask

    initial begin
        int p0, cyc;
        rst_n = 1'b0;
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single source: 11 22 from source 2
        ph[2].push_back({1'b0, 8'h11});
        ph[2].push_back({1'b1, 8'h22});
        load_phase();
        drain();

        // Fairness: two sources streaming 1-byte frames
        for (int f = 0; f < 4; f++) begin
            add_frame(0, 1);
            add_frame(1, 1);
        end
        load_phase();
        drain();

        // Truncation: 6 bytes with last on the 6th
        add_frame(3, 6);
        load_phase();
        drain();

        // Wrap: pointer at 3, requests on 0 and 3
        add_frame(2, 1);
        load_phase();
        drain();
        add_frame(0, 2);
        add_frame(3, 2);
        load_phase();
        drain();

        // Randomised traffic, alternating full-rate and 30% sink readiness
        for (int it = 0; it < 8; it++) begin
            duty = (it % 2 == 1) ? 30 : 100;
            for (int i = 0; i < NUM_SRC; i++) begin
                int nf;
                nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++) add_frame(i, $urandom_range(1, 7));
            end
            load_phase();
            drain();
        end
        duty = 100;

        // Reset mid-frame with the pointer left at 3
        add_frame(2, 1);
        load_phase();
        drain();
        p0 = popped;
        add_frame(1, 6);
        load_phase();
        cyc = 0;
        while (popped < p0 + 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_data", {31'd0, popped >= p0 + 5}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        expq.delete();
        for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
        trunc_exp = trunc_seen;
        model_rr  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        add_frame(0, 2);
        add_frame(3, 2);
        load_phase();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
